srv_tcm_host_bridge: RTL

Sits in front of one `srv_spram` TCM instance, between the core's TCM port and the RAM. Passes core accesses straight through and lets an external host (boot loader or debug agent) reach the same RAM with 32-bit requests in idle cycles. Host requests are buffered in a small FIFO, widened to the 64-bit RAM word with per-bit write enables, and returned as 32-bit read responses through a valid/ready handshake. The core always has priority and is never stalled.

---
 rtl/srv_tcm_pkg.sv | 24 ++
 rtl/srv_sync_fifo.sv | 45 ++++
 rtl/srv_tcm_host_bridge.sv | 120 ++++++++++++
 3 files changed

// File: rtl/srv_tcm_pkg.sv
// Shared types and helpers for the TCM host bridge: host request record and
// strobe-to-bit-enable expansion onto the 64-bit RAM word.
package srv_tcm_pkg;

    localparam int TCM_DW      = 64;
    localparam int HOST_DW     = 32;
    localparam int HOST_AW_MAX = 32;

    // addr is sized for the widest supported RAM; the bridge zero-extends.
    typedef struct packed {
        logic                     we;
        logic [HOST_AW_MAX-1:0]   addr;
        logic [HOST_DW-1:0]       wdata;
        logic [HOST_DW/8-1:0]     wstrb;
    } host_req_t;

    function automatic logic [TCM_DW-1:0] strb2bwe(input logic [HOST_DW/8-1:0] strb,
                                                   input logic hi);
        logic [HOST_DW-1:0] half;
        for (int i = 0; i < HOST_DW/8; i++) half[i*8 +: 8] = {8{strb[i]}};
        return hi ? {half, {HOST_DW{1'b0}}} : {{HOST_DW{1'b0}}, half};
    endfunction

endpackage

// File: rtl/srv_sync_fifo.sv
// Registered synchronous FIFO with count-based full/empty; head is visible
// on dout whenever the FIFO is non-empty.
module srv_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/srv_tcm_host_bridge.sv
// Core/host arbiter in front of a single spram TCM. Core always wins; host
// requests drain from a FIFO in idle cycles. Define SRV_TCM_HOST_RD_EN for
// the host read path; otherwise the host port is a write-only loader.
module srv_tcm_host_bridge
    import srv_tcm_pkg::*;
#(
    parameter int AW_TCM          = 16,
    parameter int HOST_FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                core_ce,
    input  logic                core_we,
    input  logic [AW_TCM-1:0]   core_addr,
    input  logic [TCM_DW-1:0]   core_bwe,
    input  logic [TCM_DW-1:0]   core_din,
    output logic [TCM_DW-1:0]   core_dout,
    output logic                ram_ce,
    output logic                ram_we,
    output logic [AW_TCM-1:0]   ram_addr,
    output logic [TCM_DW-1:0]   ram_bwe,
    output logic [TCM_DW-1:0]   ram_din,
    input  logic [TCM_DW-1:0]   ram_dout,
    input  logic                host_req_valid,
    output logic                host_req_ready,
    input  logic                host_req_we,
    input  logic [AW_TCM:0]     host_req_addr,
    input  logic [HOST_DW-1:0]  host_req_wdata,
    input  logic [3:0]          host_req_wstrb,
    output logic                host_rsp_valid,
    input  logic                host_rsp_ready,
    output logic [HOST_DW-1:0]  host_rsp_rdata,
    output logic                host_busy
);
    host_req_t req_in, head;
    logic      fifo_full, fifo_empty, issue, head_elig;
    logic      unused;

    assign core_dout      = ram_dout;
    assign host_req_ready = ~fifo_full;
    assign issue          = ~core_ce & ~fifo_empty & head_elig;

    always_comb begin
        req_in       = '0;
`ifdef SRV_TCM_HOST_RD_EN
        req_in.we    = host_req_we;
`else
        req_in.we    = 1'b1;
`endif
        req_in.addr  = HOST_AW_MAX'(host_req_addr);
        req_in.wdata = host_req_wdata;
        req_in.wstrb = host_req_wstrb;
    end

    srv_sync_fifo #(.W($bits(host_req_t)), .DEPTH(HOST_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (host_req_valid),
        .din     (req_in),
        .pop     (issue),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        ram_ce   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_bwe  = '0;
        ram_din  = '0;
        if (core_ce) begin
            ram_ce   = 1'b1;
            ram_we   = core_we;
            ram_addr = core_addr;
            ram_bwe  = core_bwe;
            ram_din  = core_din;
        end else if (issue) begin
            ram_ce   = 1'b1;
            ram_we   = head.we;
            ram_addr = head.addr[AW_TCM:1];
            ram_bwe  = head.we ? strb2bwe(head.wstrb, head.addr[0]) : '0;
            ram_din  = {head.wdata, head.wdata};
        end
    end

`ifdef SRV_TCM_HOST_RD_EN
    logic rd_pend, rd_hi;

    // A read may only leave the FIFO once the response slot is free.
    assign head_elig = head.we | (~rd_pend & ~host_rsp_valid);
    assign host_busy = ~fifo_empty | rd_pend;
    assign unused    = ^{head.addr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend        <= 1'b0;
            rd_hi          <= 1'b0;
            host_rsp_valid <= 1'b0;
            host_rsp_rdata <= '0;
        end else begin
            rd_pend <= issue & ~head.we;
            if (issue & ~head.we) rd_hi <= head.addr[0];
            if (rd_pend) begin
                host_rsp_valid <= 1'b1;
                host_rsp_rdata <= rd_hi ? ram_dout[63:32] : ram_dout[31:0];
            end else if (host_rsp_ready) begin
                host_rsp_valid <= 1'b0;
            end
        end
    end
`else
    assign head_elig      = 1'b1;
    assign host_busy      = ~fifo_empty;
    assign host_rsp_valid = 1'b0;
    assign host_rsp_rdata = '0;
    assign unused         = ^{head.addr, host_req_we, host_rsp_ready};
`endif

endmodule
